// File: rtl/miss_arbiter.sv
// Round-robin arbiter sharing one next-level block-fetch path among the per-core
// L1 miss requesters; returns the block and measured miss latency to the winner.
module miss_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_W     = 32,
  parameter int BLOCK_BITS = 128,
  parameter int LAT_W      = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  output logic [NUM_CORES-1:0]        grant,
  output logic                        mem_start,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_ready,
  input  logic [BLOCK_BITS-1:0]       mem_block,
  output logic [NUM_CORES-1:0]        done,
  output logic [BLOCK_BITS-1:0]       resp_block,
  output logic [LAT_W-1:0]            resp_latency,
  output logic [15:0]                 grant_count,
  output logic [15:0]                 stall_count
);
  localparam int PTR_W = $clog2(NUM_CORES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [NUM_CORES-1:0]   grant_q, grant_d;
  logic [NUM_CORES-1:0]   done_q, done_d;
  logic [NUM_CORES-1:0]   served_q, served_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       gidx_q, gidx_d;
  logic                   mem_start_q, mem_start_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic [BLOCK_BITS-1:0]  resp_block_q, resp_block_d;
  logic [LAT_W-1:0]       resp_latency_q, resp_latency_d;
  logic [15:0]            grant_count_q, grant_count_d;
  logic [15:0]            stall_count_q, stall_count_d;

  logic [NUM_CORES-1:0]   eligible;
  logic                   pick_found;
  logic [PTR_W-1:0]       pick_idx;
  logic [NUM_CORES-1:0]   pick_oh;
  logic [LAT_W-1:0]       lat_inc;

  function automatic logic [PTR_W-1:0] wrap_idx(input int base, input int k);
    int s;
    s = base + k;
    if (s >= NUM_CORES) s = s - NUM_CORES;
    return PTR_W'(s);
  endfunction

  // The core just served is masked for one IDLE cycle so its stale req cannot re-win.
  assign eligible = req & ~served_q;
  assign lat_inc  = (&lat_q) ? lat_q : lat_q + 1'b1;
  assign pick_oh  = {{(NUM_CORES-1){1'b0}}, 1'b1} << pick_idx;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!pick_found && eligible[wrap_idx(int'(ptr_q), k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_idx(int'(ptr_q), k);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    done_d         = '0;
    served_d       = served_q;
    ptr_d          = ptr_q;
    gidx_d         = gidx_q;
    mem_start_d    = 1'b0;
    mem_addr_d     = mem_addr_q;
    lat_d          = lat_q;
    resp_block_d   = resp_block_q;
    resp_latency_d = resp_latency_q;
    grant_count_d  = grant_count_q;
    stall_count_d  = stall_count_q;

    if ((|(req & ~grant_q)) && !(&stall_count_q))
      stall_count_d = stall_count_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        served_d = '0;
        if (pick_found) begin
          grant_d     = pick_oh;
          gidx_d      = pick_idx;
          mem_addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
          mem_start_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        lat_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready) begin
          resp_block_d   = mem_block;
          resp_latency_d = lat_inc;
          done_d         = grant_q;
          state_d        = S_DONE;
        end else begin
          lat_d = lat_inc;
        end
      end
      S_DONE: begin
        if (!(&grant_count_q)) grant_count_d = grant_count_q + 16'd1;
        ptr_d      = (int'(gidx_q) == NUM_CORES-1) ? '0 : gidx_q + 1'b1;
        served_d   = grant_q;
        grant_d    = '0;
        mem_addr_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      grant_q        <= '0;
      done_q         <= '0;
      served_q       <= '0;
      ptr_q          <= '0;
      gidx_q         <= '0;
      mem_start_q    <= 1'b0;
      mem_addr_q     <= '0;
      lat_q          <= '0;
      resp_block_q   <= '0;
      resp_latency_q <= '0;
      grant_count_q  <= '0;
      stall_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      done_q         <= done_d;
      served_q       <= served_d;
      ptr_q          <= ptr_d;
      gidx_q         <= gidx_d;
      mem_start_q    <= mem_start_d;
      mem_addr_q     <= mem_addr_d;
      lat_q          <= lat_d;
      resp_block_q   <= resp_block_d;
      resp_latency_q <= resp_latency_d;
      grant_count_q  <= grant_count_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign grant        = grant_q;
  assign done         = done_q;
  assign mem_start    = mem_start_q;
  assign mem_addr     = mem_addr_q;
  assign resp_block   = resp_block_q;
  assign resp_latency = resp_latency_q;
  assign grant_count  = grant_count_q;
  assign stall_count  = stall_count_q;
endmodule

// File: doc/miss_arbiter.md
# miss_arbiter

Round-robin arbiter that shares the single next-level block-fetch path among the per-core L1 cache controllers in the multicore simulator. Each core raises a miss request with its address. The arbiter grants one core at a time, issues a start pulse and address to the fetch unit, and waits for the block. It then returns the block and measured miss latency to the granted core with a one-cycle done pulse. It also keeps saturating contention statistics for the debug ILA.

## Interface
- NUM_CORES, 4, number of requesting cores (2..8)
- ADDR_W, 32, request address width
- BLOCK_BITS, 128, block width (block_size_byte*8)
- LAT_W, 5, latency counter width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_CORES  per-core miss request; held high until that core's done
- req_addr  in  NUM_CORES*ADDR_W  per-core address; core i in bits [i*ADDR_W +: ADDR_W], stable while req[i]
- grant  out  NUM_CORES  one-hot current owner; zero when idle
- mem_start  out  1  one-cycle pulse to fetch unit
- mem_addr  out  ADDR_W  address of granted core; valid while grant != 0
- mem_ready  in  1  fetch unit block valid (single-cycle pulse)
- mem_block  in  BLOCK_BITS  block data, valid with mem_ready
- done  out  NUM_CORES  one-hot, one-cycle completion pulse to served core
- resp_block  out  BLOCK_BITS  block latched on mem_ready; held until next capture
- resp_latency  out  LAT_W  cycles from mem_start to mem_ready, saturating at all-ones
- grant_count  out  16  total completed transactions, saturating at 0xFFFF
- stall_count  out  16  cycles with at least one requesting core not granted, saturating at 0xFFFF

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: form eligible = req & ~served_mask.
  - If eligible != 0, pick the first set bit starting at pointer ptr and searching upward with wrap-around.
  - Register the choice into grant and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: mem_start=1; mem_addr = granted core's address; clear the latency counter; go to WAIT.
- WAIT: the latency counter increments each cycle, saturating. On mem_ready:
  - Latch mem_block into resp_block.
  - Latch latency+1, saturated, into resp_latency.
  - Go to DONE.
- DONE: done = grant for one cycle.
  - grant_count increments (saturating).
  - ptr advances to (granted index + 1) mod NUM_CORES.
  - served_mask = grant; grant is cleared; go to IDLE.
- served_mask applies only during the first IDLE cycle after DONE and is then cleared. This prevents re-granting a core that has not yet dropped its registered req. If only that core requests, it is granted on the following cycle.
- stall_count increments in any cycle where (req & ~grant) != 0, in every state.
- mem_ready outside WAIT is ignored: no capture and no state change.
- Changes to req of the granted core during ISSUE or WAIT are ignored. The transaction always completes.
- Reset, including mid-transaction, gives:
  - state=IDLE; grant, done, mem_start, served_mask all 0; ptr=0.
  - resp_block, resp_latency, grant_count, stall_count all 0.
  - An in-flight fetch is abandoned. A later mem_ready is ignored because the FSM is not in WAIT.

## Timing
- All outputs are registered.
- Request seen in IDLE at cycle t: grant and mem_start at t+1 (ISSUE), WAIT from t+2.
- mem_ready at cycle w (in WAIT): done, resp_block and resp_latency valid at w+1. IDLE at w+2. Earliest next grant at w+3.
- resp_latency equals w-(t+1) when mem_ready arrives in cycle w.
- Minimum transaction time from request to done: 4 cycles, with mem_ready in the first WAIT cycle.
- Round-robin fairness: with all cores requesting continuously, each core is served exactly once per NUM_CORES transactions.

## Test plan
- Reset then idle: outputs all zero. Assert req=4'b0100 with addr 0x0000_1230 and mem_ready 3 cycles after mem_start. Required: grant=0100 with mem_start one cycle after req; mem_addr=0x1230; done=0100 one cycle after mem_ready; resp_latency=3; grant_count=1.
- req=4'b1111 held continuously, fixed 2-cycle fetch. Required: grant order 0001, 0010, 0100, 1000, 0001; no core granted twice in succession.
- Single core holding req high one extra cycle after done: no re-grant in the masked IDLE cycle; re-grant in the following cycle.
- Two cores contend, each fetch taking 5 cycles. Required: stall_count increments every cycle the loser waits, and the total matches the hand count.
- mem_ready pulsed during ISSUE and during IDLE: ignored, no done. Fetch of 40 cycles: resp_latency=31 (saturated).
- rst asserted mid-WAIT, then a late mem_ready. Required: all outputs return to reset values; no done is generated; the next grant starts from core 0.
